ifetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the 16-bit program counter. It presents the current PC to instruction memory over a request/acknowledge handshake, latches the returned word into a single-entry instruction register for the microsequencer, and drives the PC's count-enable and load/target inputs. It is the only block that advances or redirects the PC. A wait-cycle watchdog flags memory that never acknowledges.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_timer.sv | 28 ++
 rtl/ifetch_unit.sv | 126 ++++++++++++
 tb/tb_ifetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package ifetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned TIMER_W     = 8;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_t;

endpackage

// File: rtl/ifetch_timer.sv
// Wait-cycle counter for the fetch watchdog; tc flags the last allowed wait cycle.
module ifetch_timer
  import ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // Count enabled wait cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: drives the PC, fetches over a req/ack handshake,
// holds one instruction for the microsequencer and watches for a dead memory.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] pc_q,
  output logic              pc_inc,
  output logic              pc_load_n,
  output logic [ADDR_W-1:0] pc_d,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_take,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_err
);

  state_t state, state_n;

  logic ir_wr;
  logic valid_clr;
  logic err_set;
  logic t_clr;
  logic t_en;
  logic t_tc;

  assign mem_addr = pc_q;
  assign pc_d     = redirect_pc;

  ifetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(CLK),
    .clr(CLR | t_clr),
    .en (t_en),
    .tc (t_tc)
  );

  // Next-state and handshake decode; priority CLR > redirect > ack > take > timeout.
  always_comb begin
    state_n   = state;
    ir_wr     = 1'b0;
    valid_clr = 1'b0;
    err_set   = 1'b0;
    t_clr     = 1'b0;
    t_en      = 1'b0;
    mem_rd    = 1'b0;
    pc_inc    = 1'b0;
    pc_load_n = 1'b1;
    if (!CLR) begin
      case (state)
        FETCH: begin
          mem_rd = 1'b1;
          if (redirect) begin
            pc_load_n = 1'b0;
            t_clr     = 1'b1;
          end else if (mem_ack) begin
            pc_inc  = 1'b1;
            ir_wr   = 1'b1;
            t_clr   = 1'b1;
            state_n = HOLD;
          end else if (t_tc) begin
            err_set = 1'b1;
            state_n = ERR;
          end else begin
            t_en = 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_load_n = 1'b0;
            valid_clr = 1'b1;
            t_clr     = 1'b1;
            state_n   = FETCH;
          end else if (ir_take) begin
            valid_clr = 1'b1;
            state_n   = FETCH;
          end
        end
        ERR: begin
          state_n = ERR;
        end
        default: begin
          state_n = FETCH;
        end
      endcase
    end
  end

  // State, instruction register and sticky error.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= FETCH;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_wr) begin
        ir    <= mem_data;
        ir_pc <= pc_q;
      end
      if (ir_wr) begin
        ir_valid <= 1'b1;
      end else if (valid_clr || err_set) begin
        ir_valid <= 1'b0;
      end
      if (err_set) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic against a
// rule-level reference model, with a behavioural PC driven by the DUT.
module tb_ifetch_unit;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [15:0] pc_q;
  logic        pc_inc;
  logic        pc_load_n;
  logic [15:0] pc_d;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_take;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the consumer should see, by rule.
  logic [15:0] m_ir;
  logic [15:0] m_ir_pc;
  logic        m_valid;
  logic        m_err;
  int          m_wait;

  ifetch_unit #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TMO)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .pc_q       (pc_q),
    .pc_inc     (pc_inc),
    .pc_load_n  (pc_load_n),
    .pc_d       (pc_d),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .ir_valid   (ir_valid),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_take    (ir_take),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_err  (fetch_err)
  );

  always #5 CLK = ~CLK;

  // Program counter the fetch unit steers (load beats count).
  always @(posedge CLK) begin
    if (CLR) pc_q <= 16'h0000;
    else if (!pc_load_n) pc_q <= pc_d;
    else if (pc_inc) pc_q <= pc_q + 16'h0001;
  end

  function automatic logic exp_rd();
    return !CLR && !m_err && !m_valid;
  endfunction

  function automatic logic exp_inc();
    return exp_rd() && mem_ack && !redirect;
  endfunction

  function automatic logic exp_load_n();
    return !(!CLR && !m_err && redirect);
  endfunction

  // Advance the model by one cycle using the inputs now applied, then clock.
  task automatic tick();
    if (CLR) begin
      m_ir = '0; m_ir_pc = '0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
    end else if (!m_err) begin
      if (redirect) begin
        m_valid = 1'b0;
        m_wait  = 0;
      end else if (!m_valid) begin
        if (mem_ack) begin
          m_ir = mem_data; m_ir_pc = pc_q; m_valid = 1'b1; m_wait = 0;
        end else if (m_wait == TMO - 1) begin
          m_err = 1'b1;
        end else begin
          m_wait++;
        end
      end else if (ir_take) begin
        m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1; mem_ack = 1'b0; ir_take = 1'b0; redirect = 1'b0;
    tick();
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; mem_ack = 1'b1; redirect = 1'b1; ir_take = 1'b1;
    mem_data = 16'hBEEF; redirect_pc = 16'h0055;
    #3;
    n_checks++; if ({mem_rd, pc_inc, pc_load_n} !== 3'b001) $display("FAIL rst_comb: got %b want 001", {mem_rd, pc_inc, pc_load_n}); else n_pass++;
    tick();
    tick();
    #3;
    n_checks++; if ({ir, ir_pc, ir_valid, fetch_err} !== 34'd0) $display("FAIL rst_regs: ir=%h ir_pc=%h v=%b err=%b want all 0", ir, ir_pc, ir_valid, fetch_err); else n_pass++;
    CLR = 1'b0; mem_ack = 1'b0; redirect = 1'b0; ir_take = 1'b0;
    #1;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000 || ir_valid !== 1'b0) $display("FAIL rst_exit: rd=%b addr=%h v=%b want 1 0000 0", mem_rd, mem_addr, ir_valid); else n_pass++;
    tick();
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_data = 16'h1234; mem_ack = 1'b1;
    #3;
    n_checks++; if (pc_inc !== 1'b1 || pc_load_n !== 1'b1) $display("FAIL zw_inc: inc=%b load_n=%b want 1 1", pc_inc, pc_load_n); else n_pass++;
    tick();
    mem_ack = 1'b0;
    #3;
    n_checks++; if (ir !== 16'h1234 || ir_pc !== 16'h0000 || ir_valid !== 1'b1) $display("FAIL zw_ir: ir=%h pc=%h v=%b want 1234 0000 1", ir, ir_pc, ir_valid); else n_pass++;
    n_checks++; if (pc_q !== 16'h0001 || mem_rd !== 1'b0) $display("FAIL zw_pc: pc=%h rd=%b want 0001 0", pc_q, mem_rd); else n_pass++;
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    #3;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) $display("FAIL zw_next: rd=%b addr=%h want 1 0001", mem_rd, mem_addr); else n_pass++;
    tick();
  endtask

  task automatic test_delayed_ack();
    int rd_cnt  = 0;
    int inc_cnt = 0;
    logic stable = 1'b1;
    do_reset();
    mem_data = 16'hA5C3;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #3;
      rd_cnt  += int'(mem_rd);
      inc_cnt += int'(pc_inc);
      tick();
    end
    mem_ack = 1'b0; mem_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (ir !== 16'hA5C3 || ir_pc !== 16'h0000 || ir_valid !== 1'b1) stable = 1'b0;
      rd_cnt  += int'(mem_rd);
      inc_cnt += int'(pc_inc);
      tick();
    end
    n_checks++; if (rd_cnt != 4 || inc_cnt != 1) $display("FAIL dly_counts: rd=%0d inc=%0d want 4 1", rd_cnt, inc_cnt); else n_pass++;
    n_checks++; if (stable !== 1'b1) $display("FAIL dly_stable: ir=%h v=%b want a5c3 held", ir, ir_valid); else n_pass++;
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    #3;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001 || ir_valid !== 1'b0) $display("FAIL dly_next: rd=%b addr=%h v=%b want 1 0001 0", mem_rd, mem_addr, ir_valid); else n_pass++;
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    mem_ack = 1'b1; mem_data = 16'h7777; redirect = 1'b1; redirect_pc = 16'h0100;
    #3;
    n_checks++; if (pc_load_n !== 1'b0 || pc_inc !== 1'b0 || pc_d !== 16'h0100) $display("FAIL rdr_ctl: load_n=%b inc=%b d=%h want 0 0 0100", pc_load_n, pc_inc, pc_d); else n_pass++;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    #3;
    n_checks++; if (ir_valid !== 1'b0 || ir !== 16'h0000 || mem_rd !== 1'b1 || mem_addr !== 16'h0100) $display("FAIL rdr_next: v=%b ir=%h rd=%b addr=%h want 0 0000 1 0100", ir_valid, ir, mem_rd, mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_data = 16'h4242;
    tick();
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
    #3;
    n_checks++; if (pc_load_n !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 16'h0100) $display("FAIL rdr_hold: load_n=%b v=%b ir_pc=%h want 0 1 0100", pc_load_n, ir_valid, ir_pc); else n_pass++;
    tick();
    redirect = 1'b0;
    #3;
    n_checks++; if (ir_valid !== 1'b0 || mem_addr !== 16'h0200 || mem_rd !== 1'b1) $display("FAIL rdr_hold_next: v=%b addr=%h rd=%b want 0 0200 1", ir_valid, mem_addr, mem_rd); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int k = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      #3;
      if (fetch_err === 1'b1 && k < 0) k = i;
      tick();
    end
    n_checks++; if (k != TMO) $display("FAIL tmo_cycles: err after %0d cycles want %0d", k, TMO); else n_pass++;
    redirect = 1'b1; redirect_pc = 16'h3000; mem_ack = 1'b1;
    #3;
    n_checks++; if (pc_load_n !== 1'b1 || mem_rd !== 1'b0 || pc_inc !== 1'b0) $display("FAIL tmo_err_comb: load_n=%b rd=%b inc=%b want 1 0 0", pc_load_n, mem_rd, pc_inc); else n_pass++;
    tick();
    #3;
    n_checks++; if (pc_q !== 16'h0000 || ir_valid !== 1'b0 || fetch_err !== 1'b1) $display("FAIL tmo_err_hold: pc=%h v=%b err=%b want 0000 0 1", pc_q, ir_valid, fetch_err); else n_pass++;
    redirect = 1'b0; mem_ack = 1'b0; CLR = 1'b1;
    tick();
    CLR = 1'b0;
    #3;
    n_checks++; if (fetch_err !== 1'b0 || mem_rd !== 1'b1) $display("FAIL tmo_clr: err=%b rd=%b want 0 1", fetch_err, mem_rd); else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0; mem_ack = 1'b1; mem_data = 16'h0BAD;
    #3;
    n_checks++; if (mem_addr !== 16'hFFFF) $display("FAIL wrap_addr: addr=%h want ffff", mem_addr); else n_pass++;
    tick();
    mem_ack = 1'b0;
    #3;
    n_checks++; if (ir_pc !== 16'hFFFF || ir !== 16'h0BAD || pc_q !== 16'h0000) $display("FAIL wrap_ir: ir_pc=%h ir=%h pc=%h want ffff 0bad 0000", ir_pc, ir, pc_q); else n_pass++;
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    #3;
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL wrap_next: rd=%b addr=%h want 1 0000", mem_rd, mem_addr); else n_pass++;
    tick();
  endtask

  task automatic test_clr_in_hold();
    do_reset();
    mem_ack = 1'b1; mem_data = 16'h9999;
    tick();
    mem_ack = 1'b0;
    #3;
    n_checks++; if (ir_valid !== 1'b1 || ir !== 16'h9999) $display("FAIL clrh_pre: v=%b ir=%h want 1 9999", ir_valid, ir); else n_pass++;
    CLR = 1'b1; mem_ack = 1'b1;
    tick();
    CLR = 1'b0; mem_ack = 1'b0;
    #3;
    n_checks++; if (ir_valid !== 1'b0 || ir !== 16'h0000 || ir_pc !== 16'h0000 || mem_rd !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL clrh_post: v=%b ir=%h ir_pc=%h rd=%b addr=%h want 0 0000 0000 1 0000", ir_valid, ir, ir_pc, mem_rd, mem_addr); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int ack_pct;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) ack_pct = (i == 200) ? 2 : int'($urandom_range(10, 90));
      CLR         = ($urandom_range(0, 59) == 0);
      mem_ack     = ($urandom_range(0, 99) < ack_pct);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 16'($urandom);
      mem_data    = 16'($urandom);
      ir_take     = ($urandom_range(0, 2) == 0);
      #3;
      n_checks++;
      if (mem_rd !== exp_rd() || pc_inc !== exp_inc() || pc_load_n !== exp_load_n() ||
          mem_addr !== pc_q || pc_d !== redirect_pc || ir_valid !== m_valid ||
          fetch_err !== m_err || ir !== m_ir || ir_pc !== m_ir_pc)
        $display("FAIL rand_cyc%0d: rd=%b inc=%b ldn=%b v=%b err=%b ir=%h irpc=%h want rd=%b inc=%b ldn=%b v=%b err=%b ir=%h irpc=%h",
                 i, mem_rd, pc_inc, pc_load_n, ir_valid, fetch_err, ir, ir_pc,
                 exp_rd(), exp_inc(), exp_load_n(), m_valid, m_err, m_ir, m_ir_pc);
      else n_pass++;
      tick();
    end
    CLR = 1'b0; mem_ack = 1'b0; redirect = 1'b0; ir_take = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; mem_ack = 1'b0; ir_take = 1'b0; redirect = 1'b0;
    mem_data = '0; redirect_pc = '0;
    m_ir = '0; m_ir_pc = '0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_redirect();
    test_timeout();
    test_wrap();
    test_clr_in_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
